flight_mixer: RTL and testbench

- Control stage between the radio `inputs` decoder and the ESC `outputs` PWM generator.
- Consumes the packed 8×10-bit `radio_val` word and produces a packed 8×10-bit `esc_val` word.
- Contains the arming state machine, signal-loss failsafe, a quad-X motor mixer with clamping, and per-motor slew limiting, all paced by a 1 kHz tick.

---
 rtl/avionics_pkg.sv | 35 +++
 rtl/esc_slew.sv | 45 ++++
 rtl/flight_mixer.sv | 172 +++++++++++++++++
 tb/tb_flight_mixer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avionics_pkg.sv
// Shared constants, state type and mixer clamp helper for the flight control path.
package avionics_pkg;

    localparam int unsigned CH_W       = 10;
    localparam int unsigned NUM_CH     = 8;
    localparam int unsigned NUM_MOTORS = 4;
    localparam int unsigned CNT_W      = 10;

    localparam int unsigned CH_THR   = 0;
    localparam int unsigned CH_ROLL  = 1;
    localparam int unsigned CH_PITCH = 2;
    localparam int unsigned CH_YAW   = 3;
    localparam int unsigned CH_ARM   = 4;

    typedef logic [CH_W-1:0] ch_t;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        ARMED    = 2'd2,
        FAILSAFE = 2'd3
    } mix_state_t;

    function automatic ch_t clamp_mix(input logic signed [12:0] m, input ch_t lo, input ch_t hi);
        ch_t res;
        if (m < $signed({3'b000, lo}))
            res = lo;
        else if (m > $signed({3'b000, hi}))
            res = hi;
        else
            res = m[CH_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/esc_slew.sv
// One motor output register: steps toward its target by a bounded amount per
// enable, or drops straight to the minimum when forced.
module esc_slew
    import avionics_pkg::*;
#(
    parameter ch_t ESC_MIN   = 10'd0,
    parameter ch_t SLEW_STEP = 10'd20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            step_en,
    input  logic            force_min,
    input  logic [CH_W-1:0] target,
    output logic [CH_W-1:0] out
);

    logic [CH_W-1:0] r_out;
    logic [CH_W-1:0] w_next;
    logic [CH_W-1:0] w_diff;

    // Targets never go below ESC_MIN, so the downward step cannot underflow.
    always_comb begin
        w_diff = '0;
        w_next = r_out;
        if (r_out < target) begin
            w_diff = target - r_out;
            w_next = (w_diff <= SLEW_STEP) ? target : r_out + SLEW_STEP;
        end else if (r_out > target) begin
            w_diff = r_out - target;
            w_next = (w_diff <= SLEW_STEP) ? target : r_out - SLEW_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_out <= ESC_MIN;
        else if (force_min)
            r_out <= ESC_MIN;
        else if (step_en)
            r_out <= w_next;
    end

    assign out = r_out;

endmodule

// File: rtl/flight_mixer.sv
// Arming FSM, signal-loss failsafe, quad-X mixer with clamping and per-motor
// slew limiting between the radio decoder and the ESC PWM generator.
module flight_mixer
    import avionics_pkg::*;
#(
    parameter ch_t               ESC_MIN    = 10'd0,
    parameter ch_t               ESC_IDLE   = 10'd100,
    parameter ch_t               ESC_MAX    = 10'd1000,
    parameter ch_t               SLEW_STEP  = 10'd20,
    parameter ch_t               THR_LOW    = 10'd50,
    parameter ch_t               ARM_HI     = 10'd768,
    parameter ch_t               ARM_LO     = 10'd256,
    parameter logic [CNT_W-1:0]  ARM_TICKS  = 10'd1000,
    parameter logic [CNT_W-1:0]  FS_TICKS   = 10'd250,
    parameter int unsigned       GAIN_SHIFT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick_1khz,
    input  logic [NUM_CH*CH_W-1:0] radio_val,
    output logic [NUM_CH*CH_W-1:0] esc_val,
    output logic                   armed,
    output logic                   failsafe
);

    ch_t               w_ch [NUM_CH];
    logic              w_unused_ch;
    logic              w_sig_ok;
    logic              w_arm_cond;
    logic              w_disarm_req;

    logic signed [10:0] w_r, w_p, w_y;
    logic signed [12:0] w_t, w_rs, w_ps, w_ys;
    logic signed [12:0] w_mix [NUM_MOTORS];
    ch_t               r_target [NUM_MOTORS];

    mix_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_arm_cnt, w_arm_cnt_nxt;
    logic [CNT_W-1:0]  r_loss_cnt, w_loss_cnt_nxt;

    logic              w_force_min;
    logic              w_step_en;
    ch_t               w_slew_tgt [NUM_MOTORS];
    ch_t               w_esc [NUM_MOTORS];

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++)
            w_ch[i] = radio_val[i*CH_W +: CH_W];
    end

    assign w_unused_ch  = ^{w_ch[5], w_ch[6], w_ch[7]};
    assign w_sig_ok     = (w_ch[CH_THR] != '0) && (w_ch[CH_ROLL] != '0) && (w_ch[CH_PITCH] != '0)
                       && (w_ch[CH_YAW] != '0) && (w_ch[CH_ARM] != '0);
    assign w_arm_cond   = w_sig_ok && (w_ch[CH_ARM] > ARM_HI) && (w_ch[CH_THR] < THR_LOW);
    assign w_disarm_req = w_sig_ok && (w_ch[CH_ARM] < ARM_LO);

    always_comb begin
        w_r  = $signed({1'b0, w_ch[CH_ROLL]})  - 11'sd512;
        w_p  = $signed({1'b0, w_ch[CH_PITCH]}) - 11'sd512;
        w_y  = $signed({1'b0, w_ch[CH_YAW]})   - 11'sd512;
        w_rs = 13'(w_r) >>> GAIN_SHIFT;
        w_ps = 13'(w_p) >>> GAIN_SHIFT;
        w_ys = 13'(w_y) >>> GAIN_SHIFT;
        w_t  = $signed({3'b000, w_ch[CH_THR]});
        w_mix[0] = w_t + w_rs + w_ps - w_ys;
        w_mix[1] = w_t - w_rs + w_ps + w_ys;
        w_mix[2] = w_t - w_rs - w_ps - w_ys;
        w_mix[3] = w_t + w_rs - w_ps + w_ys;
    end

    // Targets hold through signal loss so the armed motors keep their last command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_MOTORS; i++)
                r_target[i] <= ESC_MIN;
        end else if (w_sig_ok) begin
            for (int unsigned i = 0; i < NUM_MOTORS; i++)
                r_target[i] <= clamp_mix(w_mix[i], ESC_IDLE, ESC_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= DISARMED;
            r_arm_cnt  <= '0;
            r_loss_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_arm_cnt  <= w_arm_cnt_nxt;
            r_loss_cnt <= w_loss_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_arm_cnt_nxt  = r_arm_cnt;
        w_loss_cnt_nxt = r_loss_cnt;
        if (tick_1khz) begin
            if (w_sig_ok)
                w_loss_cnt_nxt = '0;
            else if (r_loss_cnt < FS_TICKS)
                w_loss_cnt_nxt = r_loss_cnt + 1'b1;
        end
        case (r_state)
            DISARMED: begin
                w_arm_cnt_nxt = '0;
                if (tick_1khz && w_arm_cond) begin
                    w_state_nxt   = ARMING;
                    w_arm_cnt_nxt = CNT_W'(1);
                end
            end
            ARMING: begin
                if (tick_1khz) begin
                    if (w_arm_cond) begin
                        if (r_arm_cnt < ARM_TICKS)
                            w_arm_cnt_nxt = r_arm_cnt + 1'b1;
                        if (r_arm_cnt + 1'b1 >= ARM_TICKS)
                            w_state_nxt = ARMED;
                    end else begin
                        w_state_nxt   = DISARMED;
                        w_arm_cnt_nxt = '0;
                    end
                end
            end
            // Disarm is checked every clk so the motor cut does not wait for a tick.
            ARMED: begin
                if (w_disarm_req)
                    w_state_nxt = DISARMED;
                else if (tick_1khz && !w_sig_ok && (w_loss_cnt_nxt >= FS_TICKS))
                    w_state_nxt = FAILSAFE;
            end
            FAILSAFE: begin
                if (tick_1khz && w_disarm_req)
                    w_state_nxt = DISARMED;
            end
            default: w_state_nxt = DISARMED;
        endcase
    end

    // Slew control follows the post-transition state so a tick acts in its new state.
    always_comb begin
        armed       = (r_state == ARMED);
        failsafe    = (r_state == FAILSAFE);
        w_force_min = (w_state_nxt == DISARMED) || (w_state_nxt == ARMING);
        w_step_en   = tick_1khz && ((w_state_nxt == ARMED) || (w_state_nxt == FAILSAFE));
        for (int unsigned i = 0; i < NUM_MOTORS; i++)
            w_slew_tgt[i] = (w_state_nxt == FAILSAFE) ? ESC_MIN : r_target[i];
    end

    for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_motor
        esc_slew #(
            .ESC_MIN   (ESC_MIN),
            .SLEW_STEP (SLEW_STEP)
        ) u_slew (
            .clk       (clk),
            .rst_n     (rst_n),
            .step_en   (w_step_en),
            .force_min (w_force_min),
            .target    (w_slew_tgt[g]),
            .out       (w_esc[g])
        );
    end

    always_comb begin
        esc_val = '0;
        for (int unsigned i = 0; i < NUM_MOTORS; i++)
            esc_val[i*CH_W +: CH_W] = w_esc[i];
        for (int unsigned i = NUM_MOTORS; i < NUM_CH; i++)
            esc_val[i*CH_W +: CH_W] = ESC_MIN;
    end

endmodule

// File: tb/tb_flight_mixer.sv
// Self-checking bench for flight_mixer: directed scenarios plus randomized
// armed operation, all compared against a behavioural model of the control rules.
module tb_flight_mixer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_1khz = 1'b0;
    logic [79:0] radio_val;
    logic [79:0] esc_val;
    logic        armed;
    logic        failsafe;

    logic [9:0]  ch [8];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: 0=disarmed 1=arming 2=armed 3=failsafe
    int ms = 0;
    int m_arm = 0;
    int m_loss = 0;
    int m_out [4];
    int m_tgt [4];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++)
            radio_val[i*10 +: 10] = ch[i];
    end

    flight_mixer #(
        .ESC_MIN    (10'd0),
        .ESC_IDLE   (10'd100),
        .ESC_MAX    (10'd1000),
        .SLEW_STEP  (10'd20),
        .THR_LOW    (10'd50),
        .ARM_HI     (10'd768),
        .ARM_LO     (10'd256),
        .ARM_TICKS  (10'd1000),
        .FS_TICKS   (10'd250),
        .GAIN_SHIFT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1khz (tick_1khz),
        .radio_val (radio_val),
        .esc_val   (esc_val),
        .armed     (armed),
        .failsafe  (failsafe)
    );

    function automatic int clampi(input int v);
        if (v < 100) return 100;
        if (v > 1000) return 1000;
        return v;
    endfunction

    function automatic logic [79:0] exp_esc();
        logic [79:0] v;
        v = '0;
        for (int i = 0; i < 4; i++)
            v[i*10 +: 10] = 10'(m_out[i]);
        return v;
    endfunction

    task automatic model_clock(input bit t);
        int c [5];
        bit ok, armc;
        int r, p, y, g, d;
        if (!rst_n) begin
            ms = 0; m_arm = 0; m_loss = 0;
            for (int i = 0; i < 4; i++) begin m_out[i] = 0; m_tgt[i] = 0; end
            return;
        end
        for (int i = 0; i < 5; i++) c[i] = int'(ch[i]);
        ok   = (c[0] != 0) && (c[1] != 0) && (c[2] != 0) && (c[3] != 0) && (c[4] != 0);
        armc = ok && (c[4] > 768) && (c[0] < 50);
        if (t) m_loss = ok ? 0 : ((m_loss < 250) ? m_loss + 1 : 250);
        if (ms == 2 && ok && c[4] < 256) begin
            ms = 0;
        end else if (t) begin
            case (ms)
                0: if (armc) begin ms = 1; m_arm = 1; end
                1: if (armc) begin
                       m_arm = m_arm + 1;
                       if (m_arm >= 1000) ms = 2;
                   end else begin
                       ms = 0; m_arm = 0;
                   end
                2: if (!ok && m_loss >= 250) ms = 3;
                3: if (ok && c[4] < 256) ms = 0;
                default: ms = 0;
            endcase
        end
        if (ms <= 1) begin
            for (int i = 0; i < 4; i++) m_out[i] = 0;
        end else if (t) begin
            for (int i = 0; i < 4; i++) begin
                g = (ms == 3) ? 0 : m_tgt[i];
                d = g - m_out[i];
                if (d > 20)       m_out[i] = m_out[i] + 20;
                else if (d < -20) m_out[i] = m_out[i] - 20;
                else              m_out[i] = g;
            end
        end
        if (ok) begin
            r = (c[1] - 512) >>> 1;
            p = (c[2] - 512) >>> 1;
            y = (c[3] - 512) >>> 1;
            m_tgt[0] = clampi(c[0] + r + p - y);
            m_tgt[1] = clampi(c[0] - r + p + y);
            m_tgt[2] = clampi(c[0] - r - p - y);
            m_tgt[3] = clampi(c[0] + r - p + y);
        end
    endtask

    task automatic cycle(input bit t);
        tick_1khz = t;
        @(posedge clk);
        model_clock(t);
        #1;
        tick_1khz = 1'b0;
    endtask

    task automatic tick_period();
        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0);
    endtask

    task automatic set_sticks(input int thr, input int roll, input int pitch, input int yaw, input int arm);
        ch[0] = 10'(thr); ch[1] = 10'(roll); ch[2] = 10'(pitch); ch[3] = 10'(yaw); ch[4] = 10'(arm);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) ch[i] = 10'($urandom_range(0, 1023));
        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b1);
        n_tests++;
        if (esc_val !== 80'h0) begin n_fail++; $display("FAIL reset_esc: got %h want %h", esc_val, 80'h0); end
        n_tests++;
        if (armed !== 1'b0 || failsafe !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: armed=%b failsafe=%b want 0 0", armed, failsafe);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 4; i++) ch[i] = 10'($urandom_range(1, 1023));
            ch[4] = 10'($urandom_range(1, 700));
            tick_period();
            n_tests++;
            if (armed !== 1'b0 || failsafe !== 1'b0 || esc_val !== 80'h0) begin
                n_fail++; $display("FAIL reset_release: armed=%b failsafe=%b esc=%h want 0 0 0", armed, failsafe, esc_val);
            end
        end
    endtask

    task automatic test_arm();
        set_sticks(20, 512, 512, 512, 900);
        for (int i = 5; i < 8; i++) ch[i] = 10'($urandom_range(0, 1023));
        cycle(1'b0); cycle(1'b0);
        for (int k = 1; k <= 500; k++) begin
            tick_period();
            n_tests++;
            if (armed !== (ms == 2) || esc_val !== exp_esc()) begin
                n_fail++; $display("FAIL arm_hold k=%0d: armed=%b esc=%h want %b %h", k, armed, esc_val, ms == 2, exp_esc());
            end
        end
        ch[0] = 10'd60;
        tick_period();
        n_tests++;
        if (armed !== 1'b0 || ms != 0) begin
            n_fail++; $display("FAIL arm_abort: armed=%b model_state=%0d want 0 0", armed, ms);
        end
        ch[0] = 10'd20;
        for (int k = 1; k <= 1000; k++) begin
            tick_period();
            if (k == 999) begin
                n_tests++;
                if (armed !== 1'b0) begin n_fail++; $display("FAIL arm_999: armed=%b want 0", armed); end
            end
            if (k == 1000) begin
                n_tests++;
                if (armed !== 1'b1) begin n_fail++; $display("FAIL arm_1000: armed=%b want 1", armed); end
            end
        end
        n_tests++;
        if (esc_val !== exp_esc()) begin n_fail++; $display("FAIL arm_esc: got %h want %h", esc_val, exp_esc()); end
    endtask

    task automatic test_mix_slew();
        logic [79:0] want;
        set_sticks(500, 612, 512, 512, 900);
        cycle(1'b0); cycle(1'b0);
        for (int k = 0; k < 40; k++) begin
            tick_period();
            n_tests++;
            if (esc_val !== exp_esc()) begin
                n_fail++; $display("FAIL mix_slew k=%0d: got %h want %h", k, esc_val, exp_esc());
            end
        end
        want = {40'h0, 10'd550, 10'd450, 10'd450, 10'd550};
        n_tests++;
        if (esc_val !== want) begin n_fail++; $display("FAIL mix_settle: got %h want %h", esc_val, want); end
    endtask

    task automatic test_clamp();
        logic [79:0] want;
        set_sticks(1000, 1023, 512, 512, 900);
        cycle(1'b0); cycle(1'b0);
        for (int k = 0; k < 60; k++) begin
            tick_period();
            n_tests++;
            if (esc_val !== exp_esc()) begin n_fail++; $display("FAIL clamp_hi k=%0d: got %h want %h", k, esc_val, exp_esc()); end
        end
        want = {40'h0, 10'd1000, 10'd745, 10'd745, 10'd1000};
        n_tests++;
        if (esc_val !== want) begin n_fail++; $display("FAIL clamp_hi_final: got %h want %h", esc_val, want); end
        set_sticks(60, 0, 512, 512, 900);
        ch[1] = 10'd0;
        set_sticks(60, 1, 512, 512, 900);
        ch[1] = 10'd0;
        cycle(1'b0); cycle(1'b0);
        for (int k = 0; k < 60; k++) begin
            tick_period();
            n_tests++;
            if (esc_val !== exp_esc()) begin n_fail++; $display("FAIL clamp_lo k=%0d: got %h want %h", k, esc_val, exp_esc()); end
        end
        n_tests++;
        if (esc_val !== {40'h0, 10'd1000, 10'd745, 10'd745, 10'd1000}) begin
            n_fail++; $display("FAIL clamp_lo_hold: got %h want %h", esc_val, {40'h0, 10'd1000, 10'd745, 10'd745, 10'd1000});
        end
        ch[1] = 10'd1;
    endtask

    task automatic test_clamp_low();
        logic [79:0] want;
        set_sticks(60, 2, 512, 512, 900);
        cycle(1'b0); cycle(1'b0);
        for (int k = 0; k < 60; k++) begin
            tick_period();
            n_tests++;
            if (esc_val !== exp_esc()) begin n_fail++; $display("FAIL clamp_idle k=%0d: got %h want %h", k, esc_val, exp_esc()); end
        end
        want = {40'h0, 10'd100, 10'd315, 10'd315, 10'd100};
        n_tests++;
        if (esc_val !== want) begin n_fail++; $display("FAIL clamp_idle_final: got %h want %h", esc_val, want); end
    endtask

    task automatic test_random_armed();
        bit t;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 4; i++)
                ch[i] = ($urandom_range(0, 19) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            ch[4] = ($urandom_range(0, 19) == 0) ? 10'd0 : 10'($urandom_range(300, 1023));
            t = ($urandom_range(0, 2) == 0);
            cycle(t);
            n_tests++;
            if (esc_val !== exp_esc() || armed !== (ms == 2) || failsafe !== (ms == 3)) begin
                n_fail++;
                $display("FAIL random k=%0d: esc=%h armed=%b fs=%b want %h %b %b", k, esc_val, armed, failsafe, exp_esc(), ms == 2, ms == 3);
            end
        end
    endtask

    task automatic test_failsafe();
        logic [79:0] hold;
        hold = {40'h0, 10'd500, 10'd500, 10'd500, 10'd500};
        set_sticks(500, 512, 512, 512, 900);
        cycle(1'b0); cycle(1'b0);
        for (int k = 0; k < 40; k++) tick_period();
        n_tests++;
        if (esc_val !== hold || armed !== 1'b1) begin
            n_fail++; $display("FAIL fs_settle: esc=%h armed=%b want %h 1", esc_val, armed, hold);
        end
        set_sticks(0, 0, 0, 0, 0);
        for (int k = 1; k <= 249; k++) begin
            tick_period();
            n_tests++;
            if (esc_val !== hold || failsafe !== 1'b0) begin
                n_fail++; $display("FAIL fs_hold k=%0d: esc=%h fs=%b want %h 0", k, esc_val, failsafe, hold);
            end
        end
        tick_period();
        n_tests++;
        if (failsafe !== 1'b1 || armed !== 1'b0) begin
            n_fail++; $display("FAIL fs_enter: fs=%b armed=%b want 1 0", failsafe, armed);
        end
        for (int k = 0; k < 30; k++) begin
            tick_period();
            n_tests++;
            if (esc_val !== exp_esc()) begin n_fail++; $display("FAIL fs_ramp k=%0d: got %h want %h", k, esc_val, exp_esc()); end
        end
        n_tests++;
        if (esc_val !== 80'h0) begin n_fail++; $display("FAIL fs_floor: got %h want %h", esc_val, 80'h0); end
        set_sticks(500, 512, 512, 512, 900);
        tick_period();
        n_tests++;
        if (failsafe !== 1'b1) begin n_fail++; $display("FAIL fs_arm_high: fs=%b want 1", failsafe); end
        ch[4] = 10'd100;
        tick_period();
        n_tests++;
        if (failsafe !== 1'b0 || armed !== 1'b0 || esc_val !== 80'h0) begin
            n_fail++; $display("FAIL fs_exit: fs=%b armed=%b esc=%h want 0 0 0", failsafe, armed, esc_val);
        end
    endtask

    task automatic test_immediate_disarm();
        logic [79:0] want;
        set_sticks(20, 512, 512, 512, 900);
        cycle(1'b0); cycle(1'b0);
        for (int k = 0; k < 1000; k++) tick_period();
        n_tests++;
        if (armed !== 1'b1) begin n_fail++; $display("FAIL disarm_rearm: armed=%b want 1", armed); end
        ch[0] = 10'd800;
        cycle(1'b0); cycle(1'b0);
        for (int k = 0; k < 45; k++) tick_period();
        want = {40'h0, 10'd800, 10'd800, 10'd800, 10'd800};
        n_tests++;
        if (esc_val !== want) begin n_fail++; $display("FAIL disarm_800: got %h want %h", esc_val, want); end
        cycle(1'b1);
        cycle(1'b0);
        ch[4] = 10'd100;
        cycle(1'b0);
        cycle(1'b0);
        n_tests++;
        if (esc_val !== 80'h0 || armed !== 1'b0) begin
            n_fail++; $display("FAIL disarm_cut: esc=%h armed=%b want 0 0", esc_val, armed);
        end
        n_tests++;
        if (esc_val !== exp_esc() || ms != 0) begin
            n_fail++; $display("FAIL disarm_model: esc=%h want %h", esc_val, exp_esc());
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ch[i] = 10'd0;
        for (int i = 0; i < 4; i++) begin m_out[i] = 0; m_tgt[i] = 0; end
        test_reset();
        test_arm();
        test_mix_slew();
        test_clamp();
        test_clamp_low();
        test_random_armed();
        test_failsafe();
        test_immediate_disarm();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
